// File: rtl/multiply_add.sv
// multiply_add: sequential 32x32 unsigned multiply-accumulate.
//   result = multiplicand * multiplier + addend (64-bit, never overflows).
//   One multiplier bit is consumed per clock with a single 33-bit adder and
//   a right-shifting {hi,lo} product register. Operation takes 32 cycles
//   from the accepting edge; a start/busy/done handshake wraps the datapath.
//
// Ports:
//   clock        in   1   master clock, rising edge
//   reset        in   1   synchronous reset, active high
//   start        in   1   request a new operation (sampled only while idle)
//   multiplicand in  32   operand A, latched when start is accepted
//   multiplier   in  32   operand B, latched when start is accepted
//   addend       in  32   operand C, latched when start is accepted
//   busy         out  1   high while an operation is in progress
//   done         out  1   one-cycle pulse when result is updated
//   result       out 64   A*B+C, held until the next completion
module multiply_add (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [31:0] multiplier,
  input  logic [31:0] addend,
  output logic        busy,
  output logic        done,
  output logic [63:0] result
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] ra_q, ra_d;
  logic [32:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] result_q, result_d;
  logic        done_q, done_d;

  logic [32:0] sum;
  logic [32:0] hi_shift;
  logic [31:0] lo_shift;
  logic        last_step;

  // One shift-add step. hi is preloaded with the addend, so after 32 right
  // shifts the addend lands in the low half exactly; hi stays below 2^32,
  // hence sum always fits in 33 bits.
  always_comb begin
    sum       = hi_q + (lo_q[0] ? {1'b0, ra_q} : 33'd0);
    hi_shift  = {1'b0, sum[32:1]};
    lo_shift  = {sum[0], lo_q[31:1]};
    last_step = (cnt_q == 6'd31);
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last_step) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next-state logic
  always_comb begin
    ra_d     = ra_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ra_d  = multiplicand;
          hi_d  = {1'b0, addend};
          lo_d  = multiplier;
          cnt_d = '0;
        end
      end
      RUN: begin
        hi_d  = hi_shift;
        lo_d  = lo_shift;
        cnt_d = cnt_q + 6'd1;
        if (last_step) begin
          result_d = {hi_shift[31:0], lo_shift};
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock) begin
    if (reset) begin
      ra_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      ra_q     <= ra_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Outputs
  always_comb begin
    busy   = (state_q == RUN);
    done   = done_q;
    result = result_q;
  end

endmodule

// File: tb/tb_multiply_add.sv
module tb_multiply_add;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic [31:0] addend;
  logic        busy;
  logic        done;
  logic [63:0] result;

  int checks = 0;
  int errors = 0;
  logic [63:0] last_result;

  multiply_add dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .addend       (addend),
    .busy         (busy),
    .done         (done),
    .result       (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Waits (bounded) for done. n = edges waited, or -1 on timeout.
  // ok clears if busy drops or result moves before done.
  task automatic wait_done(input logic [63:0] held, output int n, output bit ok);
    bit seen;
    seen = 1'b0;
    ok   = 1'b1;
    n    = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      n++;
      if (done) seen = 1'b1;
      else begin
        if (busy !== 1'b1) ok = 1'b0;
        if (result !== held) ok = 1'b0;
      end
    end
    if (!seen) n = -1;
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [63:0] exp);
    int n;
    bit ok;
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    start        = 1'b1;
    tick();
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    addend       = $urandom;
    chk({name, "_busy_after_accept"}, {63'd0, busy}, 64'd1);
    wait_done(last_result, n, ok);
    chk({name, "_latency"}, 64'(n), 64'd32);
    chk({name, "_busy_hold"}, {63'd0, ok}, 64'd1);
    chk({name, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    chk({name, "_result"}, result, exp);
    last_result = exp;
    tick();
    chk({name, "_done_width"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int n;
    bit ok;
    bit quiet;
    logic [31:0] bb_a[3];
    logic [31:0] bb_b[3];
    logic [31:0] bb_c[3];
    logic [63:0] bb_e[3];

    vecs[0]  = '{32'd7,        32'd6,        32'd5,        64'd47};
    vecs[1]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFF_00000000};
    vecs[2]  = '{32'd14,       32'd7,        32'd2,        64'd100};
    vecs[3]  = '{32'h12345678, 32'd0,        32'h9,        64'd9};
    vecs[4]  = '{32'd1,        32'd1,        32'd0,        64'd1};
    vecs[5]  = '{32'd0,        32'd0,        32'd0,        64'd0};
    vecs[6]  = '{32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 64'h1_FFFFFFFE};
    vecs[7]  = '{32'h00010000, 32'h00010000, 32'd0,        64'h1_00000000};
    vecs[8]  = '{32'h80000000, 32'd2,        32'd0,        64'h1_00000000};
    vecs[9]  = '{32'd3,        32'd5,        32'hFFFFFFFF, 64'h1_0000000E};
    vecs[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        64'hFFFFFFFE_00000001};
    vecs[11] = '{32'h12345678, 32'h10,       32'd1,        64'h1_23456781};

    reset = 1'b1; start = 1'b0;
    multiplicand = '0; multiplier = '0; addend = '0;
    repeat (3) tick();
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_done", {63'd0, done}, 64'd0);
    chk("reset_result", result, 64'd0);
    reset = 1'b0;
    last_result = '0;
    tick();

    for (int i = 0; i < 12; i++) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].exp);
    end

    // Round trip against integer division
    for (int i = 0; i < 200; i++) begin
      logic [31:0] dvd, dvs;
      dvd = $urandom;
      dvs = $urandom_range(1, 32'hFFFF) << $urandom_range(0, 16);
      if (dvs == 0) dvs = 32'd1;
      do_op($sformatf("rt%0d", i), dvd / dvs, dvs, dvd % dvs, {32'd0, dvd});
    end

    // Start while busy is ignored
    multiplicand = 32'h12345678; multiplier = '0; addend = 32'h9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    multiplicand = 32'hDEADBEEF; multiplier = 32'h5; addend = 32'h77;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(last_result, n, ok);
    chk("ign_latency", 64'(n), 64'd27);
    chk("ign_hold", {63'd0, ok}, 64'd1);
    chk("ign_result", result, 64'd9);
    last_result = 64'd9;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("ign_not_queued", {63'd0, quiet}, 64'd1);

    // Back-to-back with start held high
    bb_a = '{32'd100, 32'hFFFFFFFF, 32'd3};
    bb_b = '{32'd200, 32'd2,        32'd3};
    bb_c = '{32'd1,   32'd0,        32'd3};
    bb_e = '{64'd20001, 64'h1_FFFFFFFE, 64'd12};
    multiplicand = bb_a[0]; multiplier = bb_b[0]; addend = bb_c[0];
    start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) begin
        multiplicand = bb_a[i+1]; multiplier = bb_b[i+1]; addend = bb_c[i+1];
      end else begin
        start = 1'b0;
      end
      wait_done(last_result, n, ok);
      chk($sformatf("b2b%0d_latency", i), 64'(n), 64'd32);
      chk($sformatf("b2b%0d_hold", i), {63'd0, ok}, 64'd1);
      chk($sformatf("b2b%0d_result", i), result, bb_e[i]);
      last_result = bb_e[i];
      tick();
      chk($sformatf("b2b%0d_done_width", i), {63'd0, done}, 64'd0);
      if (i < 2) chk($sformatf("b2b%0d_reaccept", i), {63'd0, busy}, 64'd1);
    end

    // Reset mid-operation
    multiplicand = 32'd7; multiplier = 32'd6; addend = 32'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_done", {63'd0, done}, 64'd0);
    chk("rst_mid_result", result, 64'd0);
    reset = 1'b0;
    last_result = '0;
    quiet = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    chk("rst_mid_no_done", {63'd0, quiet}, 64'd1);

    // Reset wins over simultaneous start
    reset = 1'b1; start = 1'b1;
    tick();
    chk("rst_start_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0; start = 1'b0;
    tick();
    chk("rst_start_idle", {63'd0, busy}, 64'd0);

    do_op("after_reset", 32'd7, 32'd6, 32'd5, 64'd47);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
